// File: rtl/rgb_led_pwm.sv
`default_nettype none
// ============================================================================
// rgb_led_pwm : three-channel PWM for the RGB LED with optional blink envelope
// Optional macro SOFT_FADE_EN : duty ramps 1 LSB per period toward target.
// Revision    : 1.0
// ============================================================================
module rgb_led_pwm #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 50
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [31:0] LED_FREQ_Qin,
  input  logic [31:0] LEDR_Puty_Qin,
  input  logic [31:0] LEDG_Puty_Qin,
  input  logic [31:0] LEDB_Puty_Qin,
  output logic        LED_R,
  output logic        LED_G,
  output logic        LED_B,
  output logic        PERIOD_STB,
  output logic        BLINK_DARK
);

  localparam int PRESC_EFF = (PRESCALE < 1) ? 1 : PRESCALE;
  localparam int PRESC_W   = (PRESC_EFF > 1) ? $clog2(PRESC_EFF) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PRESC_EFF - 1);
  localparam logic [PRESC_W-1:0]  PRESC_ONE  = PRESC_W'(1);
  localparam logic [PWM_BITS-1:0] PWM_ONE    = PWM_BITS'(1);
  localparam logic [PWM_BITS:0]   DUTY_FULL  = {1'b1, {PWM_BITS{1'b0}}};

  typedef enum logic [1:0] {
    STEADY = 2'd0,
    ON     = 2'd1,
    DARK   = 2'd2
  } blink_state_t;

  logic [PRESC_W-1:0]  presc_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS:0]   duty_r, duty_g, duty_b;
  logic [PWM_BITS:0]   tgt_r, tgt_g, tgt_b;
  logic [31:0]         blk_cnt;
  blink_state_t        state;
  logic                tick, boundary, dark;
  logic                raw_r, raw_g, raw_b;

  function automatic logic [PWM_BITS:0] saturate(input logic [31:0] v);
    if ((v >> PWM_BITS) != 32'd0) return DUTY_FULL;
    else return {1'b0, v[PWM_BITS-1:0]};
  endfunction

`ifdef SOFT_FADE_EN
  localparam logic [PWM_BITS:0] DUTY_ONE = (PWM_BITS + 1)'(1);

  function automatic logic [PWM_BITS:0] step(input logic [PWM_BITS:0] cur,
                                             input logic [PWM_BITS:0] tgt);
    if (cur < tgt)      return cur + DUTY_ONE;
    else if (cur > tgt) return cur - DUTY_ONE;
    else                return cur;
  endfunction
`endif

  assign tick     = (presc_cnt == PRESC_LAST);
  assign boundary = tick && (&pwm_cnt);
  assign dark     = (state == DARK);
  assign tgt_r    = saturate(LEDR_Puty_Qin);
  assign tgt_g    = saturate(LEDG_Puty_Qin);
  assign tgt_b    = saturate(LEDB_Puty_Qin);
  assign raw_r    = ({1'b0, pwm_cnt} < duty_r);
  assign raw_g    = ({1'b0, pwm_cnt} < duty_g);
  assign raw_b    = ({1'b0, pwm_cnt} < duty_b);

  // The blink FSM consumes LED_FREQ_Qin only at the boundary, i.e. exactly the
  // value a frequency shadow would capture there, so no separate copy is kept.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      presc_cnt  <= '0;
      pwm_cnt    <= '0;
      duty_r     <= '0;
      duty_g     <= '0;
      duty_b     <= '0;
      blk_cnt    <= '0;
      state      <= STEADY;
      LED_R      <= 1'b0;
      LED_G      <= 1'b0;
      LED_B      <= 1'b0;
      PERIOD_STB <= 1'b0;
      BLINK_DARK <= 1'b0;
    end else begin
      presc_cnt  <= tick ? '0 : presc_cnt + PRESC_ONE;
      if (tick) pwm_cnt <= pwm_cnt + PWM_ONE;
      PERIOD_STB <= boundary;
      LED_R      <= raw_r && !dark;
      LED_G      <= raw_g && !dark;
      LED_B      <= raw_b && !dark;
      BLINK_DARK <= dark;
      if (boundary) begin
`ifdef SOFT_FADE_EN
        duty_r <= step(duty_r, tgt_r);
        duty_g <= step(duty_g, tgt_g);
        duty_b <= step(duty_b, tgt_b);
`else
        duty_r <= tgt_r;
        duty_g <= tgt_g;
        duty_b <= tgt_b;
`endif
        case (state)
          STEADY: begin
            if (LED_FREQ_Qin != 32'd0) begin
              state   <= ON;
              blk_cnt <= '0;
            end
          end
          ON, DARK: begin
            if (LED_FREQ_Qin == 32'd0) begin
              state   <= STEADY;
              blk_cnt <= '0;
            end else if (blk_cnt >= LED_FREQ_Qin - 32'd1) begin
              state   <= (state == ON) ? DARK : ON;
              blk_cnt <= '0;
            end else begin
              blk_cnt <= blk_cnt + 32'd1;
            end
          end
          default: begin
            state   <= STEADY;
            blk_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_pwm.sv
`default_nettype none
// Bench for rgb_led_pwm (PWM_BITS=4, PRESCALE=2): random stimulus vs. period-level model.
module tb_rgb_led_pwm;

  localparam int PER = 32;
  localparam int PRE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] freq = '0, duty_r = '0, duty_g = '0, duty_b = '0;
  logic        led_r, led_g, led_b, stb, bdark;

  int n_cmp = 0;
  int n_err = 0;

  rgb_led_pwm #(.PWM_BITS(4), .PRESCALE(2)) dut (
    .CLK(clk), .RST_n(rst_n), .LED_FREQ_Qin(freq),
    .LEDR_Puty_Qin(duty_r), .LEDG_Puty_Qin(duty_g), .LEDB_Puty_Qin(duty_b),
    .LED_R(led_r), .LED_G(led_g), .LED_B(led_b),
    .PERIOD_STB(stb), .BLINK_DARK(bdark)
  );

  always #5 clk = ~clk;

  // Period-level model: cycle index since reset, per-period duty and blink mode
  int     m_cyc = 0;
  int     m_dr = 0, m_dg = 0, m_db = 0;
  int     m_mode = 0;  // 0 steady, 1 lit, 2 dark
  longint m_el = 0;
  logic   e_r = 0, e_g = 0, e_b = 0, e_stb = 0, e_dark = 0;
  logic [4:0] exp_vec, got_vec;
  assign exp_vec = {e_r, e_g, e_b, e_stb, e_dark};
  assign got_vec = {led_r, led_g, led_b, stb, bdark};

  function automatic int sat(input logic [31:0] v);
    return (v >= 32'd16) ? 16 : int'(v);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0; m_dr <= 0; m_dg <= 0; m_db <= 0; m_mode <= 0; m_el <= 0;
      e_r <= 0; e_g <= 0; e_b <= 0; e_stb <= 0; e_dark <= 0;
    end else begin
      m_cyc  <= m_cyc + 1;
      e_r    <= ((m_cyc % PER) / PRE < m_dr) && (m_mode != 2);
      e_g    <= ((m_cyc % PER) / PRE < m_dg) && (m_mode != 2);
      e_b    <= ((m_cyc % PER) / PRE < m_db) && (m_mode != 2);
      e_stb  <= (m_cyc % PER) == PER - 1;
      e_dark <= (m_mode == 2);
      if ((m_cyc % PER) == PER - 1) begin
`ifdef SOFT_FADE_EN
        m_dr <= m_dr + int'(sat(duty_r) > m_dr) - int'(sat(duty_r) < m_dr);
        m_dg <= m_dg + int'(sat(duty_g) > m_dg) - int'(sat(duty_g) < m_dg);
        m_db <= m_db + int'(sat(duty_b) > m_db) - int'(sat(duty_b) < m_db);
`else
        m_dr <= sat(duty_r);
        m_dg <= sat(duty_g);
        m_db <= sat(duty_b);
`endif
        if (freq == 32'd0) begin
          m_mode <= 0; m_el <= 0;
        end else if (m_mode == 0) begin
          m_mode <= 1; m_el <= 0;
        end else if (m_el + 1 >= longint'(freq)) begin
          m_mode <= 3 - m_mode; m_el <= 0;
        end else begin
          m_el <= m_el + 1;
        end
      end
    end
  end

  task automatic wait_stb();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stb) return;
    end
    n_cmp++; n_err++;
    $display("FAIL wait_stb: no PERIOD_STB within 100 cycles");
  endtask

  task automatic test_reset();
    int first, second;
    first = -1; second = -1;
    rst_n = 1'b0;
    duty_r = 32'd8; duty_g = 32'd8; duty_b = 32'd8; freq = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (got_vec !== 5'b0) begin
        n_err++; $display("FAIL reset_hold: got %b expected 00000", got_vec);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_err++; $display("FAIL reset_model k=%0d: got %b expected %b", k, got_vec, exp_vec);
      end
      if (stb && first < 0) first = k;
      else if (stb && second < 0) second = k;
    end
    n_cmp++;
    if (first !== 32) begin n_err++; $display("FAIL first_stb: got %0d expected 32", first); end
    n_cmp++;
    if (second !== 64) begin n_err++; $display("FAIL second_stb: got %0d expected 64", second); end
  endtask

  task automatic test_duty();
    int hr, hg, hb;
    hr = 0; hg = 0; hb = 0;
    @(negedge clk);
    duty_r = 32'd4; duty_g = 32'd0; duty_b = 32'd16; freq = '0;
    wait_stb();
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_err++; $display("FAIL duty_model k=%0d: got %b expected %b", k, got_vec, exp_vec);
      end
      hr += int'(led_r); hg += int'(led_g); hb += int'(led_b);
      if (k == 1) begin
        n_cmp++;
        if (led_r !== 1'b1) begin n_err++; $display("FAIL duty_r_start: got %b expected 1", led_r); end
      end
    end
    n_cmp++;
    if (hr != 8) begin n_err++; $display("FAIL duty_r_high: got %0d expected 8", hr); end
    n_cmp++;
    if (hg != 0) begin n_err++; $display("FAIL duty_g_high: got %0d expected 0", hg); end
    n_cmp++;
    if (hb != 32) begin n_err++; $display("FAIL duty_b_high: got %0d expected 32", hb); end
  endtask

  task automatic test_sat_midwrite();
    int h1, h2;
    logic at33, at37;
    h1 = 0; h2 = 0; at33 = 1'b0; at37 = 1'b1;
    @(negedge clk);
    duty_r = 32'h100; duty_g = $urandom; duty_b = $urandom_range(0, 16);
    wait_stb();
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_err++; $display("FAIL sat_model k=%0d: got %b expected %b", k, got_vec, exp_vec);
      end
      if (k <= 32) h1 += int'(led_r); else h2 += int'(led_r);
      if (k == 33) at33 = led_r;
      if (k == 37) at37 = led_r;
      if (k == 10) duty_r = 32'd2;
    end
    n_cmp++;
    if (h1 != 32) begin n_err++; $display("FAIL sat_full: got %0d expected 32", h1); end
    n_cmp++;
    if (h2 != 4) begin n_err++; $display("FAIL midwrite_next: got %0d expected 4", h2); end
    n_cmp++;
    if (at33 !== 1'b1 || at37 !== 1'b0) begin
      n_err++; $display("FAIL midwrite_shape: got %b%b expected 10", at33, at37);
    end
  endtask

  task automatic test_blink();
    int blk[5];
    foreach (blk[i]) blk[i] = 0;
    @(negedge clk);
    duty_r = 32'd16; freq = 32'd2;
    duty_g = $urandom_range(0, 16); duty_b = $urandom_range(0, 16);
    wait_stb();
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_err++; $display("FAIL blink_model k=%0d: got %b expected %b", k, got_vec, exp_vec);
      end
      n_cmp++;
      if (bdark !== ~led_r) begin
        n_err++; $display("FAIL blink_complement k=%0d: got dark=%b led=%b", k, bdark, led_r);
      end
      if (k <= 64) blk[0] += int'(led_r);
      else if (k <= 128) blk[1] += int'(led_r);
      else if (k <= 192) blk[2] += int'(led_r);
      else if (k <= 224) blk[3] += int'(led_r);
      else blk[4] += int'(led_r);
      if (k == 200) freq = '0;
    end
    n_cmp++;
    if (blk[0] != 64 || blk[1] != 0 || blk[2] != 64 || blk[3] != 0 || blk[4] != 32) begin
      n_err++;
      $display("FAIL blink_runs: got %0d %0d %0d %0d %0d expected 64 0 64 0 32",
               blk[0], blk[1], blk[2], blk[3], blk[4]);
    end
  endtask

  task automatic test_async_reset();
    int h0, h1, darks;
    h0 = 0; h1 = 0; darks = 0;
    @(negedge clk);
    duty_r = 32'd16; duty_g = '0; duty_b = '0; freq = '0;
    wait_stb(); wait_stb();
    @(negedge clk);
    n_cmp++;
    if (led_r !== 1'b1) begin n_err++; $display("FAIL pre_reset_led: got %b expected 1", led_r); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (got_vec !== 5'b0) begin n_err++; $display("FAIL async_reset: got %b expected 00000", got_vec); end
    freq = 32'd2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_err++; $display("FAIL rst_model k=%0d: got %b expected %b", k, got_vec, exp_vec);
      end
      if (k <= 32) h0 += int'(led_r);
      else if (k <= 96) h1 += int'(led_r);
      if (k <= 96) darks += int'(bdark);
      if (k == 100) begin
        n_cmp++;
        if (bdark !== 1'b1) begin n_err++; $display("FAIL rst_dark_after: got %b expected 1", bdark); end
      end
    end
    n_cmp++;
    if (h0 != 0 || h1 != 64 || darks != 0) begin
      n_err++; $display("FAIL rst_restart: got %0d %0d %0d expected 0 64 0", h0, h1, darks);
    end
    @(negedge clk);
    freq = '0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      duty_r = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 16));
      duty_g = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 16));
      duty_b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 16));
      freq   = 32'($urandom_range(0, 3));
      for (int k = 0; k < int'($urandom_range(20, 90)); k++) begin
        @(negedge clk);
        n_cmp++;
        if (got_vec !== exp_vec) begin
          n_err++; $display("FAIL random r=%0d k=%0d: got %b expected %b", r, k, got_vec, exp_vec);
        end
      end
    end
  endtask

  task automatic test_duty_step();
    int up[5];
    int dn[4];
    int h;
`ifdef SOFT_FADE_EN
    up = '{2, 4, 6, 8, 8};
    dn = '{6, 4, 2, 0};
`else
    up = '{8, 8, 8, 8, 8};
    dn = '{0, 0, 0, 0};
`endif
    @(negedge clk);
    duty_r = '0; freq = '0;
    repeat (20) wait_stb();
    @(negedge clk);
    duty_r = 32'd4;
    wait_stb();
    for (int p = 0; p < 5; p++) begin
      h = 0;
      for (int k = 0; k < 32; k++) begin @(negedge clk); h += int'(led_r); end
      n_cmp++;
      if (h != up[p]) begin n_err++; $display("FAIL step_up p=%0d: got %0d expected %0d", p, h, up[p]); end
    end
    duty_r = '0;
    wait_stb();
    for (int p = 0; p < 4; p++) begin
      h = 0;
      for (int k = 0; k < 32; k++) begin @(negedge clk); h += int'(led_r); end
      n_cmp++;
      if (h != dn[p]) begin n_err++; $display("FAIL step_down p=%0d: got %0d expected %0d", p, h, dn[p]); end
    end
  endtask

  initial begin
    test_reset();
    test_duty();
    test_sat_midwrite();
    test_blink();
    test_async_reset();
    test_random();
    test_duty_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgb_led_pwm.md
Name: rgb_led_pwm

Overview:
- Downstream consumer of the FlexBus peripheral register bank. Converts the software-written LED_FREQ and LEDR/LEDG/LEDB duty registers into three glitch-free PWM drives for the on-board RGB LED, with an optional blink envelope.
- Inputs are quasi-static register values. They are sampled only at PWM period boundaries, so CPU writes never produce runt pulses.

Parameters:
- PWM_BITS, 8: duty resolution. A PWM period is 2^PWM_BITS ticks.
- PRESCALE, 50: CLK cycles per PWM tick. Legal range is 1..65535; a value of 0 is treated as 1.

Ports:
- CLK  input  1  same clock net as the register bank (FB_CLK); rising-edge.
- RST_n  input  1  reset, asynchronous, active-low.
- LED_FREQ_Qin  input  32  blink half-period, in PWM periods. 0 = steady (no blink).
- LEDR_Puty_Qin  input  32  red duty.
- LEDG_Puty_Qin  input  32  green duty.
- LEDB_Puty_Qin  input  32  blue duty.
- LED_R  output  1  red PWM, active-high, registered.
- LED_G  output  1  green PWM, active-high, registered.
- LED_B  output  1  blue PWM, active-high, registered.
- PERIOD_STB  output  1  one-CLK pulse on the last cycle of each PWM period.
- BLINK_DARK  output  1  1 while the blink FSM is in the DARK state.

Behaviour:
- Reset: all outputs 0. Prescaler, pwm_cnt, blink counter and all shadow registers are 0; FSM is in STEADY. Reset is asynchronous and may occur mid-period; outputs go to 0 immediately.
- Prescaler: counts 0..PRESCALE-1. tick = (presc_cnt == PRESCALE-1).
- pwm_cnt: PWM_BITS wide, increments on tick, wraps from 2^PWM_BITS-1 to 0.
- Boundary: boundary = tick && pwm_cnt == all-ones. PERIOD_STB = boundary, registered, so it asserts the cycle after the condition.
- Duty saturation: applied to each Puty input to form a PWM_BITS+1-bit target.
  - Value >= 2^PWM_BITS (any bit above PWM_BITS-1 set) → target = 2^PWM_BITS.
  - Otherwise target = the low PWM_BITS bits.
- Shadow load: on boundary, duty_sh_x <= target and freq_sh <= LED_FREQ_Qin. Input changes at any other time have no effect until the next boundary.
- Compare: raw_x = (pwm_cnt < duty_sh_x).
  - duty 0 → output never high.
  - duty 2^PWM_BITS → output always high.
  - duty d → output high for d ticks, starting at pwm_cnt = 0.
- Output register: LED_x <= raw_x && !dark. This adds one CLK of latency relative to pwm_cnt.
- Blink FSM, evaluated only on boundary using the freshly loaded freq_sh:
  - STEADY: if freq_sh != 0 → go to ON, blk_cnt = 0.
  - ON: if freq_sh == 0 → STEADY. Else if blk_cnt >= freq_sh-1 → DARK, blk_cnt = 0. Else blk_cnt++.
  - DARK: same rule as ON, with the toggle target ON.
  - A reduced freq_sh that is already exceeded by blk_cnt toggles at the next boundary. Counters never wrap past freq_sh.
  - dark = (state == DARK). BLINK_DARK is registered.
- blk_cnt width is 32 bits; no overflow is possible because it always stays below freq_sh.
- Timing of a duty change: after an input change, the new duty first appears in the period that starts after the next boundary. Worst-case latency is 2^PWM_BITS·PRESCALE + 1 CLK.

Optional Feature:
- Macro: SOFT_FADE_EN.
- Defined: on each boundary, each effective duty_sh_x moves 1 LSB toward its saturated target; it is unchanged when equal to the target. A full 0→2^PWM_BITS swing therefore takes 2^PWM_BITS periods. Blink behaviour is unaffected.
- Undefined: duty_sh_x = target directly on boundary; no ramp logic is synthesised.

Test Plan:
- Config for all tests: PWM_BITS=4, PRESCALE=2, so one period = 32 CLK.
- Reset: hold RST_n=0 with all duty inputs = 8 → LED_R/G/B, PERIOD_STB and BLINK_DARK stay 0. Release → first PERIOD_STB after 32 CLK; thereafter one pulse every 32 CLK.
- Duty: R=4, G=0, B=16, FREQ=0 → from the second period: LED_R high 8 of 32 CLK, starting 1 CLK after pwm_cnt=0; LED_G constantly 0; LED_B constantly 1.
- Saturation and mid-period write: R=32'h100 → LED_R constantly 1. Change R to 2 at pwm_cnt=5 → current period unchanged; the next period shows a 4-CLK high pulse with no runt.
- Blink: R=16, FREQ=2 → LED_R high 64 CLK, low 64 CLK, repeating; BLINK_DARK is the complement. Set FREQ=0 while DARK → returns to steady-on at the next boundary.
- Reset mid-operation: assert RST_n in the ON phase with LED_R high → LED_R drops in the same cycle, no clock edge needed. After release, FSM restarts in STEADY.
- SOFT_FADE_EN defined: R step 0→4 → successive periods show 2, 4, 6, 8 CLK high pulses, then hold at 8. Step 4→0 → 6, 4, 2, 0.
